// File: rtl/io_bus_initiator.sv
// io_bus_initiator: initiator side of the memory-mapped IO port.
// Accepts word/byte read/write requests from a core, issues them on the io_* bus for one cycle
// each, tracks outstanding reads through a fixed-latency valid pipe, and buffers returned read
// data in an in-order show-ahead FIFO. A credit check on req_ready keeps the FIFO from overflowing.
// Ports:
//   main_clk, reset                   clock (rising edge), async active-high reset
//   req_valid/req_ready               request handshake
//   req_write/req_byte/req_address/req_data   request payload
//   rsp_valid/rsp_ready/rsp_data      read response handshake and data
//   io_address/io_data_write/io_control       registered bus outputs toward the responder
//   io_data_read                      read data from the responder
module io_bus_initiator #(
    parameter int unsigned RSP_DEPTH       = 4,
    parameter int unsigned IO_READ_LATENCY = 2
) (
    input  logic        main_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_address,
    input  logic [15:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [31:0] io_address,
    output logic [15:0] io_data_write,
    output logic [1:0]  io_control,
    input  logic [15:0] io_data_read
);

    localparam int unsigned PTR_W  = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W  = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned PIPE_W = IO_READ_LATENCY + 1;

    logic              accept;
    logic              accept_read;
    logic              push;
    logic              pop;
    logic [PIPE_W-1:0] rd_pipe;
    logic [CNT_W-1:0]  inflight_reads;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credits_used;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [15:0]       fifo_mem [RSP_DEPTH];

    // Every accepted read owns a FIFO slot from accept until it is popped.
    assign credits_used = (CNT_W+1)'(inflight_reads) + (CNT_W+1)'(fifo_count);
    assign req_ready    = !reset && (credits_used < (CNT_W+1)'(RSP_DEPTH));
    assign accept       = req_valid && req_ready;
    assign accept_read  = accept && !req_write;
    // rd_pipe[k] is set during bus cycle T+k of a read issued in cycle T.
    assign push         = rd_pipe[IO_READ_LATENCY];
    assign rsp_valid    = (fifo_count != '0);
    assign pop          = rsp_valid && rsp_ready;
    assign rsp_data     = fifo_mem[rd_ptr];

    // Issue stage: one bus cycle per accepted request, idle zeros otherwise.
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            io_address    <= '0;
            io_data_write <= '0;
            io_control    <= 2'b00;
        end else if (accept) begin
            io_address    <= req_address;
            io_data_write <= (req_write && req_byte) ? {req_data[7:0], req_data[7:0]} : req_data;
            io_control    <= {req_write, req_byte};
        end else begin
            io_address    <= '0;
            io_data_write <= '0;
            io_control    <= 2'b00;
        end
    end

    // Read-valid pipe and in-flight read counter.
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            rd_pipe        <= '0;
            inflight_reads <= '0;
        end else begin
            rd_pipe <= {rd_pipe[PIPE_W-2:0], accept_read};
            if (accept_read && !push) begin
                inflight_reads <= inflight_reads + CNT_W'(1);
            end else if (!accept_read && push) begin
                inflight_reads <= inflight_reads - CNT_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves the count unchanged.
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care while the count is zero.
    always_ff @(posedge main_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= io_data_read;
        end
    end

endmodule

// File: tb/tb_io_bus_initiator.sv
module tb_io_bus_initiator;

    localparam int unsigned RSP_DEPTH       = 4;
    localparam int unsigned IO_READ_LATENCY = 2;

    logic        main_clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [31:0] req_address = '0;
    logic [15:0] req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [31:0] io_address;
    logic [15:0] io_data_write;
    logic [1:0]  io_control;
    logic [15:0] io_data_read = '0;
    logic [15:0] resp_s1 = '0;

    io_bus_initiator #(.RSP_DEPTH(RSP_DEPTH), .IO_READ_LATENCY(IO_READ_LATENCY)) dut (
        .main_clk(main_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_byte(req_byte),
        .req_address(req_address), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .io_address(io_address), .io_data_write(io_data_write), .io_control(io_control),
        .io_data_read(io_data_read)
    );

    initial forever #5 main_clk = ~main_clk;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] addr;
        logic [15:0] wdata;
    } bus_op_t;

    bus_op_t     bus_q[$];
    logic [15:0] rsp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          ncyc = 0;
    int          rsp_seen = 0;
    int          lat_probe = -1;
    logic        probe_arm = 1'b0;
    logic        rst_next = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Responder contents: a fixed function of address, byte reads zero-extended.
    function automatic logic [15:0] resp_fn(input logic [31:0] a, input logic byte_op);
        logic [15:0] w;
        if (a == 32'h8010_0002) w = 16'hBEEF;
        else w = a[15:0] ^ {a[23:16], a[31:24]} ^ 16'h3C5A;
        return byte_op ? {8'h00, w[7:0]} : w;
    endfunction

    // Two-register responder: data for bus cycle T is on io_data_read in cycle T+2.
    always @(posedge main_clk) begin
        resp_s1      <= io_control[1] ? 16'hDEAD : resp_fn(io_address, io_control[0]);
        io_data_read <= resp_s1;
    end

    // One request cycle: drive at negedge, predict req_ready from outstanding reads, log accepts.
    task automatic drive(input logic v, input logic w, input logic b, input logic [31:0] a,
                         input logic [15:0] d, input logic rr, output logic acc);
        bus_op_t op;
        @(negedge main_clk);
        reset = rst_next;
        if (rst_next) begin
            bus_q.delete();
            rsp_q.delete();
            lat_probe = -1;
        end
        req_valid = v; req_write = w; req_byte = b; req_address = a; req_data = d; rsp_ready = rr;
        #1;
        check("req_ready", 64'(req_ready), 64'(!reset && (rsp_q.size() < RSP_DEPTH)));
        acc = v && req_ready;
        if (acc && !w && probe_arm) begin
            lat_probe = ncyc;
            probe_arm = 1'b0;
        end
        @(posedge main_clk);
        if (acc) begin
            op.ctrl  = {w, b};
            op.addr  = a;
            op.wdata = (w && b) ? {d[7:0], d[7:0]} : d;
            bus_q.push_back(op);
            if (!w) rsp_q.push_back(resp_fn(a, b));
        end
    endtask

    task automatic idle(input int n, input logic rr);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, rr, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (rsp_q.size() != 0 || bus_q.size() != 0); i++) idle(1, 1'b1);
        check("drain_empty", 64'(rsp_q.size()), 64'(0));
    endtask

    // Monitor: bus ops against the issue log, responses against the in-order read scoreboard.
    initial begin
        bus_op_t op;
        forever begin
            @(negedge main_clk);
            ncyc++;
            #2;
            if (bus_q.size() != 0) begin
                op = bus_q.pop_front();
                check("io_control", 64'(io_control), 64'(op.ctrl));
                check("io_address", 64'(io_address), 64'(op.addr));
                check("io_data_write", 64'(io_data_write), 64'(op.wdata));
            end else begin
                check("bus_idle", 64'({io_control, io_address, io_data_write}), 64'(0));
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got rsp_data=%h required no response", rsp_data);
                end else begin
                    check("rsp_data", 64'(rsp_data), 64'(rsp_q[0]));
                    if (lat_probe >= 0) begin
                        check("rsp_latency", 64'(ncyc - lat_probe), 64'(IO_READ_LATENCY + 2));
                        lat_probe = -1;
                    end
                    if (rsp_ready) begin
                        void'(rsp_q.pop_front());
                        rsp_seen++;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        int          base;
        int          idx;
        int          nacc;
        logic [31:0] addrs [6];

        // Reset state
        rst_next = 1'b1;
        idle(3, 1'b1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_io", 64'({io_control, io_address, io_data_write}), 64'(0));
        rst_next = 1'b0;

        // Word read returning BEEF, with latency probe
        base = rsp_seen;
        probe_arm = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h8010_0002, 16'h0, 1'b1, acc);
        check("beef_accept", 64'(acc), 64'(1));
        idle(6, 1'b1);
        check("beef_rsp_count", 64'(rsp_seen - base), 64'(1));

        // Byte write: replicated data, no response
        base = rsp_seen;
        drive(1'b1, 1'b1, 1'b1, 32'h8020_0005, 16'h12A5, 1'b1, acc);
        check("bwrite_accept", 64'(acc), 64'(1));
        idle(6, 1'b1);
        check("bwrite_rsp_count", 64'(rsp_seen - base), 64'(0));

        // Six back-to-back reads with the consumer stalled
        for (int i = 0; i < 6; i++) addrs[i] = 32'h8030_0000 + 32'(i * 2);
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 6) drive(1'b1, 1'b0, 1'b0, addrs[idx], 16'h0, 1'b0, acc);
            else idle(1, 1'b0);
            if (acc) idx++;
        end
        check("stall_accepted", 64'(idx), 64'(4));
        check("stall_rsp_valid", 64'(rsp_valid), 64'(1));
        for (int c = 0; c < 40 && idx < 6; c++) begin
            drive(1'b1, 1'b0, 1'b0, addrs[idx], 16'h0, 1'b1, acc);
            if (acc) idx++;
        end
        check("stall_all_accepted", 64'(idx), 64'(6));
        drain();

        // Interleaved write/read/write/read
        base = rsp_seen;
        nacc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i % 2 == 0), 1'b0, 32'h8040_0010 + 32'(i * 4), 16'h1000 + 16'(i), 1'b1, acc);
            if (acc) nacc++;
        end
        check("interleave_accepts", 64'(nacc), 64'(4));
        drain();
        check("interleave_rsp_count", 64'(rsp_seen - base), 64'(2));

        // Sustained reads with a continuously ready consumer
        base = rsp_seen;
        nacc = 0;
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, 1'b0, 1'b0, $urandom, 16'h0, 1'b1, acc);
            if (acc) nacc++;
        end
        check("sustain_rate", 64'(nacc >= 45), 64'(1));
        drain();
        check("sustain_rsp_count", 64'(rsp_seen - base), 64'(nacc));

        // Reset with two reads in flight and one buffered
        drive(1'b1, 1'b0, 1'b0, 32'h8050_0000, 16'h0, 1'b0, acc);
        idle(1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h8050_0002, 16'h0, 1'b0, acc);
        drive(1'b1, 1'b0, 1'b0, 32'h8050_0004, 16'h0, 1'b0, acc);
        @(negedge main_clk);
        check("prereset_rsp_valid", 64'(rsp_valid), 64'(1));
        reset = 1'b1;
        rst_next = 1'b1;
        bus_q.delete();
        rsp_q.delete();
        #1;
        check("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midreset_io_control", 64'(io_control), 64'(0));
        check("midreset_req_ready", 64'(req_ready), 64'(0));
        idle(2, 1'b1);
        rst_next = 1'b0;
        base = rsp_seen;
        drive(1'b1, 1'b0, 1'b0, 32'h8060_0008, 16'h0, 1'b1, acc);
        check("postreset_first_accept", 64'(acc), 64'(1));
        idle(10, 1'b1);
        check("postreset_rsp_count", 64'(rsp_seen - base), 64'(1));

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), $urandom,
                  16'($urandom), 1'($urandom_range(0, 2) != 0), acc);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
